// File: rtl/keypad_digit_entry_if.sv
// Keypad-side and display-side signals of the digit entry block.
// The master modport is the entry block itself; slave is whoever drives the keys and watches the display.
interface keypad_digit_entry_if #(
    parameter int NUM_DIGITS = 8
);
    localparam int CW = $clog2(NUM_DIGITS);

    logic [11:0]             keypad_in;
    logic                    key_valid;
    logic [3:0]              key_code;
    logic [CW-1:0]           cursor;
    logic                    commit;
    logic [7*NUM_DIGITS-1:0] seg_data;
    logic [6:0]              data_out;
    logic [NUM_DIGITS-1:0]   data_pos;
    // debounce FSM state: 0=IDLE 1=ARMING 2=HELD 3=RELEASING
    logic [1:0]              dbg_state;

    // key_valid and commit are single-cycle pulses with no backpressure:
    // the receiver must take them in the cycle they are high.
    modport master (
        input  keypad_in,
        output key_valid, key_code, cursor, commit, seg_data,
        output data_out, data_pos, dbg_state
    );

    modport slave (
        output keypad_in,
        input  key_valid, key_code, cursor, commit, seg_data,
        input  data_out, data_pos, dbg_state
    );
endinterface

// File: rtl/keypad_digit_entry.sv
// Debounces a one-hot 12-key keypad, edits a 7-segment buffer under a cursor,
// commits it on '*', and scans the committed digits onto a multiplexed segment bus.
module keypad_digit_entry #(
    parameter int NUM_DIGITS = 8,
    parameter int DEBOUNCE   = 16,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    keypad_digit_entry_if.master  bus
);
    localparam int CW = $clog2(NUM_DIGITS);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [15:0]   DB_LAST   = 16'(DEBOUNCE - 1);
    localparam logic [PW-1:0] PS_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        RELEASING = 2'd3
    } state_t;

    // ---------------- helpers ----------------
    function automatic logic is_onehot(input logic [11:0] k);
        return (k != 12'd0) && ((k & (k - 12'd1)) == 12'd0);
    endfunction

    function automatic logic [3:0] encode_key(input logic [11:0] k);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (k[i]) c = 4'(i + 1);
        end
        if (k[9])  c = 4'd0;
        if (k[10]) c = 4'd10;
        if (k[11]) c = 4'd11;
        return c;
    endfunction

    function automatic logic [6:0] digit_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1111110;
            4'd1:    p = 7'b0110000;
            4'd2:    p = 7'b1101101;
            4'd3:    p = 7'b1111001;
            4'd4:    p = 7'b0110011;
            4'd5:    p = 7'b1011011;
            4'd6:    p = 7'b1011111;
            4'd7:    p = 7'b1110010;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1111011;
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

    // ---------------- state ----------------
    logic [11:0]                 samp_q;
    state_t                      state_q, state_d;
    logic [15:0]                 cnt_q, cnt_d;
    logic [11:0]                 stored_q, stored_d;
    logic                        key_valid_q, key_valid_d;
    logic [3:0]                  key_code_q, key_code_d;
    logic [CW-1:0]               cursor_q, cursor_d;
    logic                        commit_q, commit_d;
    logic [NUM_DIGITS-1:0][6:0]  edit_q, edit_d;
    logic [NUM_DIGITS-1:0][6:0]  seg_q, seg_d;
    logic [PW-1:0]               prescaler_q, prescaler_d;
    logic [CW-1:0]               slot_q, slot_d;
    logic [NUM_DIGITS-1:0]       data_pos_q, data_pos_d;
    logic [6:0]                  data_out_q, data_out_d;
    logic                        accept;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            samp_q   <= 12'd0;
            state_q  <= IDLE;
            cnt_q    <= 16'd0;
            stored_q <= 12'd0;
        end else begin
            samp_q   <= bus.keypad_in;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stored_q <= stored_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stored_d = stored_q;
        case (state_q)
            IDLE: begin
                if (is_onehot(samp_q)) begin
                    state_d  = ARMING;
                    stored_d = samp_q;
                    cnt_d    = 16'd0;
                end
            end
            ARMING: begin
                if (samp_q == stored_q) begin
                    if (cnt_q == DB_LAST) state_d = HELD;
                    else                  cnt_d   = cnt_q + 16'd1;
                end else if (is_onehot(samp_q)) begin
                    stored_d = samp_q;
                    cnt_d    = 16'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            HELD: begin
                // other keys pressed while held are ignored until a full release
                if (samp_q == 12'd0) begin
                    state_d = RELEASING;
                    cnt_d   = 16'd0;
                end
            end
            RELEASING: begin
                if (samp_q == 12'd0) begin
                    if (cnt_q == DB_LAST) state_d = IDLE;
                    else                  cnt_d   = cnt_q + 16'd1;
                end else begin
                    state_d = HELD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        accept      = (state_q == ARMING) && (samp_q == stored_q) && (cnt_q == DB_LAST);
        key_valid_d = accept;
        key_code_d  = accept ? encode_key(stored_q) : key_code_q;
    end

    // ---------------- key actions ----------------
    always_comb begin
        edit_d   = edit_q;
        seg_d    = seg_q;
        cursor_d = cursor_q;
        commit_d = 1'b0;
        if (key_valid_q) begin
            if (key_code_q <= 4'd9) begin
                edit_d[cursor_q] = digit_pattern(key_code_q);
            end else if (key_code_q == 4'd11) begin
                cursor_d = (cursor_q == SLOT_LAST) ? '0 : cursor_q + CW'(1);
            end else begin
                seg_d    = edit_q;
                commit_d = 1'b1;
                cursor_d = '0;
            end
        end
    end

    // ---------------- scan ----------------
    always_comb begin
        prescaler_d = prescaler_q + PW'(1);
        slot_d      = slot_q;
        if (prescaler_q == PS_LAST) begin
            prescaler_d = '0;
            slot_d      = (slot_q == SLOT_LAST) ? '0 : slot_q + CW'(1);
        end
        // both follow slot_q/seg_q by one cycle so they always describe the same slot
        data_pos_d = NUM_DIGITS'(1) << slot_q;
        data_out_d = seg_q[slot_q];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            cursor_q    <= '0;
            commit_q    <= 1'b0;
            edit_q      <= '0;
            seg_q       <= '0;
            prescaler_q <= '0;
            slot_q      <= '0;
            data_pos_q  <= NUM_DIGITS'(1);
            data_out_q  <= 7'd0;
        end else begin
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            cursor_q    <= cursor_d;
            commit_q    <= commit_d;
            edit_q      <= edit_d;
            seg_q       <= seg_d;
            prescaler_q <= prescaler_d;
            slot_q      <= slot_d;
            data_pos_q  <= data_pos_d;
            data_out_q  <= data_out_d;
        end
    end

    assign bus.key_valid = key_valid_q;
    assign bus.key_code  = key_code_q;
    assign bus.cursor    = cursor_q;
    assign bus.commit    = commit_q;
    assign bus.seg_data  = seg_q;
    assign bus.data_out  = data_out_q;
    assign bus.data_pos  = data_pos_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_keypad_digit_entry.sv
// Directed bench for keypad_digit_entry with DEBOUNCE=4, SCAN_DIV=3, NUM_DIGITS=8.
module tb_keypad_digit_entry;
    localparam int ND = 8;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulse_cnt  = 0;
    int   commit_cnt = 0;
    logic [63:0] exp_q[$];

    keypad_digit_entry_if #(.NUM_DIGITS(ND)) bus ();

    keypad_digit_entry #(.NUM_DIGITS(ND), .DEBOUNCE(4), .SCAN_DIV(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (bus.key_valid) pulse_cnt++;
        if (bus.commit)    commit_cnt++;
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [11:0] key);
        bus.keypad_in = key;
        repeat (10) step();
        bus.keypad_in = 12'd0;
        repeat (8) step();
    endtask

    // key must have been driven just before the call; expects a pulse after the 6th edge only
    task automatic check_latency(input string tag, input logic [3:0] code);
        for (int k = 1; k <= 6; k++) begin
            step();
            check_eq($sformatf("%s_kv_e%0d", tag, k), 64'(bus.key_valid), 64'(k == 6));
        end
        check_eq({tag, "_code"}, 64'(bus.key_code), 64'(code));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          p0;
        int          c0;
        logic [55:0] exp_seg;
        logic        found;
        logic [7:0]  prev_pos;
        int          s;
        logic [6:0]  exp_out;

        exp_seg = '0;
        exp_seg[6:0]  = 7'b0110000;
        exp_seg[13:7] = 7'b1101101;

        // 1. reset with a key held
        rst = 1'b0;
        bus.keypad_in = 12'h010;
        repeat (5) step();
        check_eq("rst_key_valid", 64'(bus.key_valid), 64'd0);
        check_eq("rst_key_code",  64'(bus.key_code),  64'd0);
        check_eq("rst_cursor",    64'(bus.cursor),    64'd0);
        check_eq("rst_commit",    64'(bus.commit),    64'd0);
        check_eq("rst_seg_data",  64'(bus.seg_data),  64'd0);
        check_eq("rst_data_out",  64'(bus.data_out),  64'd0);
        check_eq("rst_data_pos",  64'(bus.data_pos),  64'h01);
        check_eq("rst_state",     64'(bus.dbg_state), 64'd0);
        rst = 1'b1;
        check_latency("t1", 4'd5);
        repeat (50) step();
        check_eq("t1_pulses", 64'(pulse_cnt), 64'd1);
        bus.keypad_in = 12'd0;
        repeat (8) step();

        // 2. steady '5'
        p0 = pulse_cnt;
        bus.keypad_in = 12'h010;
        check_latency("t2", 4'd5);
        repeat (50) step();
        check_eq("t2_single_pulse", 64'(pulse_cnt - p0), 64'd1);
        bus.keypad_in = 12'd0;
        repeat (8) step();

        // 3. bounce then steady
        p0 = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            bus.keypad_in = 12'h010;
            repeat (2) step();
            bus.keypad_in = 12'd0;
            repeat (2) step();
        end
        check_eq("t3_bounce_pulses", 64'(pulse_cnt - p0), 64'd0);
        bus.keypad_in = 12'h010;
        check_latency("t3", 4'd5);
        bus.keypad_in = 12'd0;
        repeat (8) step();
        check_eq("t3_pulses", 64'(pulse_cnt - p0), 64'd1);

        // 4. enter 1, #, 2, *
        c0 = commit_cnt;
        press(12'h001);
        check_eq("t4_code_1", 64'(bus.key_code), 64'd1);
        check_eq("t4_no_commit_edit", 64'(bus.seg_data), 64'd0);
        press(12'h800);
        check_eq("t4_cursor_1", 64'(bus.cursor), 64'd1);
        press(12'h002);
        check_eq("t4_code_2", 64'(bus.key_code), 64'd2);
        check_eq("t4_cursor_kept", 64'(bus.cursor), 64'd1);
        press(12'h400);
        check_eq("t4_commit_pulses", 64'(commit_cnt - c0), 64'd1);
        check_eq("t4_seg_data", 64'(bus.seg_data), 64'(exp_seg));
        check_eq("t4_cursor_0", 64'(bus.cursor), 64'd0);
        check_eq("t4_code_star", 64'(bus.key_code), 64'd10);

        // 5. cursor wrap
        for (int i = 0; i < 9; i++) exp_q.push_back(64'((i + 1) % ND));
        for (int i = 0; i < 9; i++) begin
            press(12'h800);
            check_eq($sformatf("t5_cursor_%0d", i), 64'(bus.cursor), exp_q.pop_front());
        end
        c0 = commit_cnt;
        press(12'h400);
        check_eq("t5_cursor_star", 64'(bus.cursor), 64'd0);
        check_eq("t5_commit", 64'(commit_cnt - c0), 64'd1);
        check_eq("t5_seg_data", 64'(bus.seg_data), 64'(exp_seg));

        // 6. scan
        found = 1'b0;
        prev_pos = bus.data_pos;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (bus.data_pos == 8'h01 && prev_pos != 8'h01) found = 1'b1;
            prev_pos = bus.data_pos;
        end
        check_eq("t6_scan_sync", 64'(found), 64'd1);
        if (found) begin
            for (int j = 0; j < 27; j++) begin
                s = (j / 3) % ND;
                exp_out = (s == 0) ? 7'b0110000 : (s == 1) ? 7'b1101101 : 7'b0000000;
                check_eq($sformatf("t6_pos_%0d", j), 64'(bus.data_pos), 64'(8'h01 << s));
                check_eq($sformatf("t6_out_%0d", j), 64'(bus.data_out), 64'(exp_out));
                step();
            end
        end

        // 7. reset during ARMING
        p0 = pulse_cnt;
        bus.keypad_in = 12'h004;
        repeat (3) step();
        check_eq("t7_arming", 64'(bus.dbg_state), 64'd1);
        rst = 1'b0;
        step();
        step();
        bus.keypad_in = 12'd0;
        step();
        rst = 1'b1;
        repeat (10) step();
        check_eq("t7_suppressed", 64'(pulse_cnt - p0), 64'd0);
        check_eq("t7_seg_cleared", 64'(bus.seg_data), 64'd0);
        check_eq("t7_code_cleared", 64'(bus.key_code), 64'd0);
        bus.keypad_in = 12'h004;
        check_latency("t7", 4'd3);
        bus.keypad_in = 12'd0;
        repeat (8) step();

        // 8. multi-key and key change while held
        p0 = pulse_cnt;
        press(12'h003);
        check_eq("t8_multi_ignored", 64'(pulse_cnt - p0), 64'd0);
        bus.keypad_in = 12'h002;
        repeat (8) step();
        bus.keypad_in = 12'h001;
        repeat (10) step();
        bus.keypad_in = 12'd0;
        repeat (8) step();
        check_eq("t8_held_pulses", 64'(pulse_cnt - p0), 64'd1);
        check_eq("t8_code", 64'(bus.key_code), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
